xer_cr_wb: RTL
==============

Name: xer_cr_wb

Overview:
- Architectural owner of XER and CR; sits at the writeback end of the ALU.
- Consumes the ALU flag bundle D = {CA, OV, CR0 LT/GT/EQ, CRX LT/GT/EQ} plus per-instruction update enables, and folds them into XER and CR.
- Drives the XERrd value back to the ALU for adde/subfe, and the CR/XER values read by mfcr/mfspr.
- One-deep pending stage with flush:
  - a killed instruction never reaches architectural state;
  - a dependent instruction issued the next cycle still sees the forwarded flags.

Parameters:
- ARCH_WIDTH, 32, data/register width; bit 0 is MSB.
- D_WIDTH, 8, ALU flag bundle width.
- CRF_NUM, 8, number of 4-bit CR fields.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_d  in  8  ALU flags; [0]=CA, [1]=OV, [2:4]=CR0 LT/GT/EQ, [5:7]=CRX LT/GT/EQ.
- upd_valid  in  1  ALU instruction flag update this cycle.
- upd_ca  in  1  write XER[CA].
- upd_ov  in  1  OE form: write XER[OV], accumulate SO.
- upd_cr0  in  1  Rc form: write CR field 0.
- upd_crx  in  1  compare: write CR field crx_sel.
- crx_sel  in  3  target CR field for upd_crx.
- mtxer_valid  in  1  mtspr XER.
- mtxer_data  in  32  mtspr source.
- mtcrf_valid  in  1  mtcrf.
- mtcrf_fxm  in  8  field mask; fxm[i] selects CR[4i:4i+3].
- mtcrf_data  in  32  mtcrf source.
- flush  in  1  kill pending entry and any same-cycle request.
- xer_rd  out  32  forwarded XER (pending if valid, else arch); feeds ALU XERrd.
- cr_rd  out  32  forwarded CR.
- xer_arch  out  32  committed XER.
- cr_arch  out  32  committed CR.
- pend_valid  out  1  pending entry occupied.

Behaviour:
- Reset (async, rst_n=0):
  - xer_arch=0, cr_arch=0, pend_valid=0, pending values=0.
  - xer_rd=0 and cr_rd=0 immediately.
  - Reset mid-operation discards the pending entry.
- XER layout: SO=bit0, OV=bit1, CA=bit2, bits 25:31 byte count, bits 3:24 always 0.
- Request sources: upd_valid, mtxer_valid, mtcrf_valid are exclusive by contract. If several are asserted, priority is upd > mtxer > mtcrf and the losers are dropped.
- Capture (cycle N, request present, flush=0): compute next values from the forwarded view (xer_rd/cr_rd at N), store them in the pending stage, set pend_valid=1 at the N edge.
  - ALU update:
    - upd_ov: OV'=D[1], SO'=SO|D[1] (sticky). Otherwise OV and SO are unchanged.
    - upd_ca: CA'=D[0].
    - upd_cr0: CR[0:3]={D[2:4],SO'}.
    - upd_crx: CR[4n:4n+3]={D[5:7],SO'}, n=crx_sel.
    - If upd_cr0 and upd_crx both target field 0, the CRX value wins.
  - mtxer: XER'=mtxer_data with bits 3:24 forced to 0.
  - mtcrf: each field i with fxm[i]=1 takes mtcrf_data[4i:4i+3]; the others hold.
  - A request with all enables 0 (upd_valid only) still occupies pending, with values unchanged.
- Commit: in any cycle with pend_valid=1 and flush=0, arch <= pending at the edge.
  - If a new request arrives in the same cycle, it is captured into pending at that same edge, computed from the forwarded (old pending) view, so updates chain back-to-back with no bubble.
  - With no new request, pend_valid falls to 0.
- Flush: at the edge, pend_valid<=0, arch unchanged, same-cycle request dropped. forwarded outputs revert to arch after the edge.
- Forwarding: xer_rd = pend_valid ? pend_xer : xer_arch (same for CR), purely combinational from registers. Latency request→xer_rd is 1 cycle; request→xer_arch is 2 cycles if the next cycle is not flushed.
- No stall/ready: the block accepts one request every cycle.

Decomposition:
- Shared definitions header: XER bit indices (SO/OV/CA), CR field width, the alu_d sub-field ranges (CA/OV/CR0/CRX) matching the ALU D ordering, and the reset value constants.
- One natural sub-module, xer_cr_next: combinational next-value computation for all request types. The top holds the pending and arch registers, forwarding, and flush.

Test Plan:
1. Reset: rst_n low mid-stream with pend_valid=1 → all outputs 0 immediately; pend_valid=0.
2. addo. sequence: upd_valid, upd_ov=1, upd_cr0=1, alu_d=8'b0110_0000 → next cycle xer_rd=32'hC000_0000, cr_rd[0:3]=4'b1001. Two cycles later xer_arch is the same. A following upd_ov with D[1]=0 → OV=0, SO stays 1.
3. Back-to-back adde chain: cycle N upd_ca with CA=1, cycle N+1 upd_ca with CA=0 → xer_rd[2]=1 after N, 0 after N+1; xer_arch follows one cycle later; no bubble.
4. cmp to cr6: upd_crx=1, crx_sel=6, alu_d[5:7]=3'b010, SO=1 → cr_rd[24:27]=4'b0101; other fields unchanged.
5. Flush: capture mtxer_data=32'hFFFF_FFFF, then flush=1 the next cycle together with an mtcrf request → xer_arch stays 0, pend_valid=0, mtcrf dropped, xer_rd returns to 0.
6. mtcrf fxm=8'h81, data=32'hA000_0005 → cr field0=4'hA, field7=4'h5, fields 1–6 hold. mtxer data=32'hFFFF_FFFF → XER=32'hE000_007F.

Source files
------------

// File: rtl/xer_cr_wb_pkg.sv
// Shared definitions for the XER/CR writeback block: widths, bit indices, reset values.
// Architectural bit k (bit 0 = MSB) lives at vector index WIDTH-1-k.
package xer_cr_wb_pkg;

  localparam int unsigned ARCH_WIDTH = 32;
  localparam int unsigned D_WIDTH    = 8;
  localparam int unsigned CRF_NUM    = 8;
  localparam int unsigned CRF_W      = 4;
  localparam int unsigned CRF_SEL_W  = 3;

  localparam int unsigned XER_SO_IDX = ARCH_WIDTH - 1;
  localparam int unsigned XER_OV_IDX = ARCH_WIDTH - 2;
  localparam int unsigned XER_CA_IDX = ARCH_WIDTH - 3;

  // alu_d ordering: D[0]=CA, D[1]=OV, D[2:4]=CR0 LT/GT/EQ, D[5:7]=CRX LT/GT/EQ
  localparam int unsigned D_CA_IDX = D_WIDTH - 1;
  localparam int unsigned D_OV_IDX = D_WIDTH - 2;
  localparam int unsigned D_CR0_HI = D_WIDTH - 3;
  localparam int unsigned D_CRX_HI = D_WIDTH - 6;

  // SO/OV/CA plus the 7-bit byte count; bits 3:24 read as zero
  localparam logic [ARCH_WIDTH-1:0] XER_WMASK = 32'hE000_007F;
  localparam logic [ARCH_WIDTH-1:0] XER_RST   = '0;
  localparam logic [ARCH_WIDTH-1:0] CR_RST    = '0;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_UPD   = 2'd1,
    REQ_MTXER = 2'd2,
    REQ_MTCRF = 2'd3
  } req_kind_e;

  function automatic int unsigned crf_hi(input int unsigned f);
    return ARCH_WIDTH - 1 - CRF_W * f;
  endfunction

endpackage

// File: rtl/xer_cr_wb_next.sv
// Combinational next XER/CR for ALU flag updates, mtspr XER and mtcrf.
// Requests are resolved upd > mtxer > mtcrf; the current view is the forwarded one.
module xer_cr_wb_next
  import xer_cr_wb_pkg::*;
(
  input  logic [ARCH_WIDTH-1:0] i_xer,
  input  logic [ARCH_WIDTH-1:0] i_cr,
  input  logic [D_WIDTH-1:0]    i_alu_d,
  input  logic                  i_upd_valid,
  input  logic                  i_upd_ca,
  input  logic                  i_upd_ov,
  input  logic                  i_upd_cr0,
  input  logic                  i_upd_crx,
  input  logic [CRF_SEL_W-1:0]  i_crx_sel,
  input  logic                  i_mtxer_valid,
  input  logic [ARCH_WIDTH-1:0] i_mtxer_data,
  input  logic                  i_mtcrf_valid,
  input  logic [CRF_NUM-1:0]    i_mtcrf_fxm,
  input  logic [ARCH_WIDTH-1:0] i_mtcrf_data,
  output logic                  o_req_c,
  output logic [ARCH_WIDTH-1:0] o_xer_c,
  output logic [ARCH_WIDTH-1:0] o_cr_c
);

  req_kind_e w_kind;
  logic      w_so;

  always_comb begin
    w_kind = REQ_NONE;
    if (i_upd_valid)        w_kind = REQ_UPD;
    else if (i_mtxer_valid) w_kind = REQ_MTXER;
    else if (i_mtcrf_valid) w_kind = REQ_MTCRF;
  end

  assign o_req_c = (w_kind != REQ_NONE);

  // CRX is written after CR0 so it wins when both target field 0
  always_comb begin
    o_xer_c = i_xer;
    o_cr_c  = i_cr;
    w_so    = i_xer[XER_SO_IDX];
    case (w_kind)
      REQ_UPD: begin
        if (i_upd_ov) begin
          w_so                = i_xer[XER_SO_IDX] | i_alu_d[D_OV_IDX];
          o_xer_c[XER_OV_IDX] = i_alu_d[D_OV_IDX];
          o_xer_c[XER_SO_IDX] = w_so;
        end
        if (i_upd_ca) o_xer_c[XER_CA_IDX] = i_alu_d[D_CA_IDX];
        if (i_upd_cr0) o_cr_c[crf_hi(0) -: CRF_W] = {i_alu_d[D_CR0_HI -: 3], w_so};
        for (int unsigned f = 0; f < CRF_NUM; f++) begin
          if (i_upd_crx && (i_crx_sel == CRF_SEL_W'(f)))
            o_cr_c[crf_hi(f) -: CRF_W] = {i_alu_d[D_CRX_HI -: 3], w_so};
        end
      end
      REQ_MTXER: o_xer_c = i_mtxer_data & XER_WMASK;
      REQ_MTCRF: begin
        for (int unsigned f = 0; f < CRF_NUM; f++) begin
          if (i_mtcrf_fxm[CRF_NUM-1-f])
            o_cr_c[crf_hi(f) -: CRF_W] = i_mtcrf_data[crf_hi(f) -: CRF_W];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/xer_cr_wb.sv
// XER/CR architectural owner: one-deep pending stage with flush, forwarding to the ALU
// and to mfcr/mfspr. Pending commits on the next unflushed edge.
module xer_cr_wb
  import xer_cr_wb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [D_WIDTH-1:0]    alu_d,
  input  logic                  upd_valid,
  input  logic                  upd_ca,
  input  logic                  upd_ov,
  input  logic                  upd_cr0,
  input  logic                  upd_crx,
  input  logic [CRF_SEL_W-1:0]  crx_sel,
  input  logic                  mtxer_valid,
  input  logic [ARCH_WIDTH-1:0] mtxer_data,
  input  logic                  mtcrf_valid,
  input  logic [CRF_NUM-1:0]    mtcrf_fxm,
  input  logic [ARCH_WIDTH-1:0] mtcrf_data,
  input  logic                  flush,
  output logic [ARCH_WIDTH-1:0] xer_rd,
  output logic [ARCH_WIDTH-1:0] cr_rd,
  output logic [ARCH_WIDTH-1:0] xer_arch,
  output logic [ARCH_WIDTH-1:0] cr_arch,
  output logic                  pend_valid
);

  logic [ARCH_WIDTH-1:0] r_xer_arch, r_cr_arch, r_xer_pend, r_cr_pend;
  logic                  r_pend_valid;
  logic                  w_req;
  logic [ARCH_WIDTH-1:0] w_xer_nxt, w_cr_nxt;

  xer_cr_wb_next u_next (
    .i_xer         (xer_rd),
    .i_cr          (cr_rd),
    .i_alu_d       (alu_d),
    .i_upd_valid   (upd_valid),
    .i_upd_ca      (upd_ca),
    .i_upd_ov      (upd_ov),
    .i_upd_cr0     (upd_cr0),
    .i_upd_crx     (upd_crx),
    .i_crx_sel     (crx_sel),
    .i_mtxer_valid (mtxer_valid),
    .i_mtxer_data  (mtxer_data),
    .i_mtcrf_valid (mtcrf_valid),
    .i_mtcrf_fxm   (mtcrf_fxm),
    .i_mtcrf_data  (mtcrf_data),
    .o_req_c       (w_req),
    .o_xer_c       (w_xer_nxt),
    .o_cr_c        (w_cr_nxt)
  );

  // Flush kills both the pending entry and any same-cycle request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xer_arch   <= XER_RST;
      r_cr_arch    <= CR_RST;
      r_xer_pend   <= XER_RST;
      r_cr_pend    <= CR_RST;
      r_pend_valid <= 1'b0;
    end else if (flush) begin
      r_pend_valid <= 1'b0;
    end else begin
      if (r_pend_valid) begin
        r_xer_arch <= r_xer_pend;
        r_cr_arch  <= r_cr_pend;
      end
      if (w_req) begin
        r_xer_pend <= w_xer_nxt;
        r_cr_pend  <= w_cr_nxt;
      end
      r_pend_valid <= w_req;
    end
  end

  assign xer_rd     = r_pend_valid ? r_xer_pend : r_xer_arch;
  assign cr_rd      = r_pend_valid ? r_cr_pend  : r_cr_arch;
  assign xer_arch   = r_xer_arch;
  assign cr_arch    = r_cr_arch;
  assign pend_valid = r_pend_valid;

endmodule
